// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU I/O port and interrupt unit.
// FSM encodings, default sizes and a clog2 helper that never returns 0.
package cpu_io_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_t;

   localparam int NPORTS_DEF = 4;
   localparam int DW_DEF     = 8;
   localparam int NIRQ_DEF   = 4;

   // A selector or id always needs at least one bit, even for a single item.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cpu_io_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, id=0 when nothing is set.
module cpu_io_prio_enc
   import cpu_io_pkg::*;
#(
   parameter int NIRQ = NIRQ_DEF,
   parameter int IDW  = clog2_min1(NIRQ)
) (
   input  logic [NIRQ-1:0] req,
   output logic            valid,
   output logic [IDW-1:0]  id
);

   assign valid = |req;

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      id = '0;
      for (int k = NIRQ - 1; k >= 0; k--) begin
         if (req[k]) id = IDW'(k);
      end
   end

endmodule

// File: rtl/cpu_io_irq_unit.sv
// Parametrised I/O ports plus masked, edge-captured, fixed-priority interrupt unit.
// Define CPUIO_INPUT_SYNC_EN to put a 2-flop synchroniser on i_bus and irq_in.
module cpu_io_irq_unit
   import cpu_io_pkg::*;
#(
   parameter int NPORTS = NPORTS_DEF,
   parameter int DW     = DW_DEF,
   parameter int NIRQ   = NIRQ_DEF,
   parameter int SELW   = clog2_min1(NPORTS),
   parameter int IDW    = clog2_min1(NIRQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SELW-1:0]      port_sel,
   input  logic                 wr_en,
   input  logic [DW-1:0]        wdata,
   output logic [DW-1:0]        rdata,
   output logic [NPORTS*DW-1:0] o_bus,
   input  logic [NPORTS*DW-1:0] i_bus,
   input  logic                 mask_we,
   input  logic [NIRQ-1:0]      mask_wdata,
   input  logic [NIRQ-1:0]      irq_in,
   output logic                 irq_req,
   output logic [IDW-1:0]       irq_id,
   input  logic                 irq_ack,
   input  logic                 irq_eoi,
   output logic                 in_service,
   output logic [NIRQ-1:0]      pending
);

   logic [NPORTS*DW-1:0] o_q, in_q;
   logic [NIRQ-1:0]      irq_q, irq_prev, pend_q, mask_q, rise, pend_clr;
   logic [IDW-1:0]       id_q, enc_id;
   logic                 enc_v;
   irq_state_t           st, st_n;

   // ---------------- input sampling ----------------
`ifdef CPUIO_INPUT_SYNC_EN
   logic [NPORTS*DW-1:0] in_s1;
   logic [NIRQ-1:0]      irq_s1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_s1  <= '0;
         irq_s1 <= '0;
         in_q   <= '0;
         irq_q  <= '0;
      end else begin
         in_s1  <= i_bus;
         irq_s1 <= irq_in;
         in_q   <= in_s1;
         irq_q  <= irq_s1;
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_q  <= '0;
         irq_q <= '0;
      end else begin
         in_q  <= i_bus;
         irq_q <= irq_in;
      end
   end
`endif

   // Selector values past the last port match no slice, so reads give 0 and writes drop.
   always_comb begin
      rdata = '0;
      for (int k = 0; k < NPORTS; k++) begin
         if (port_sel == SELW'(k)) rdata = in_q[k*DW +: DW];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_q <= '0;
      end else begin
         for (int k = 0; k < NPORTS; k++) begin
            if (wr_en && port_sel == SELW'(k)) o_q[k*DW +: DW] <= wdata;
         end
      end
   end

   assign o_bus = o_q;

   // ---------------- edge capture / mask ----------------
   assign rise = irq_q & ~irq_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_prev <= '0;
         pend_q   <= '0;
         mask_q   <= '0;
      end else begin
         irq_prev <= irq_q;
         pend_q   <= (pend_q & ~pend_clr) | rise;  // a fresh edge beats the ack clear
         if (mask_we) mask_q <= mask_wdata;
      end
   end

   assign pending = pend_q;

   cpu_io_prio_enc #(.NIRQ(NIRQ), .IDW(IDW)) u_enc (
      .req   (pend_q & mask_q),
      .valid (enc_v),
      .id    (enc_id)
   );

   // ---------------- request FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st   <= IDLE;
         id_q <= '0;
      end else begin
         st <= st_n;
         if (st == IDLE && enc_v) id_q <= enc_id;
      end
   end

   always_comb begin
      st_n = st;
      case (st)
         IDLE:    if (enc_v)   st_n = REQ;
         REQ:     if (irq_ack) st_n = SERVICE;
         SERVICE: if (irq_eoi) st_n = IDLE;
         default:              st_n = IDLE;
      endcase
   end

   always_comb begin
      irq_req    = (st == REQ);
      in_service = (st == SERVICE);
      pend_clr   = '0;
      if (st == REQ && irq_ack) pend_clr[id_q] = 1'b1;
   end

   assign irq_id = id_q;

endmodule
